// File: rtl/sevenseg_scan_decoder.sv
// Receive-side decoder for a multiplexed active-low seven-segment bus: captures
// each digit after a stable dwell and rebuilds the displayed N-digit hex value.
module sevenseg_scan_decoder #(
  parameter int unsigned NUM_DIGITS     = 8,
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned FCNT_W         = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_DIGITS-1:0]   an_in,
  input  logic [6:0]              seg_in,
  output logic [4*NUM_DIGITS-1:0] digit_val,
  output logic [NUM_DIGITS-1:0]   digit_blank,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic [NUM_DIGITS-1:0]   digit_seen,
  output logic                    frame_valid,
  output logic [FCNT_W-1:0]       frame_count,
  output logic                    an_err,
  output logic                    timeout
);

  localparam int unsigned BUS_W  = NUM_DIGITS + 7;
  localparam int unsigned CNT_W  = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam int unsigned IDLE_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_QUAL  = CNT_W'(STABLE_CYCLES - 2);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [6:0]        SEG_BLANK = 7'h7F;

  logic [BUS_W-1:0]      sync1, sync2, held;
  logic [CNT_W-1:0]      stable_cnt;
  logic                  dwell_done;
  logic [IDLE_W-1:0]     idle_cnt;

  logic [NUM_DIGITS-1:0] an_low;
  logic                  same, qualify, one_low, capture, multi_low, is_blank;
  logic [4:0]            dec;

  // Returns {hit, nibble} for a gfedcba active-low pattern.
  function automatic logic [4:0] seg_decode(input logic [6:0] pat);
    logic [4:0] r;
    r = 5'h00;
    case (pat)
      7'b1000000: r = {1'b1, 4'h0};
      7'b1111001: r = {1'b1, 4'h1};
      7'b0100100: r = {1'b1, 4'h2};
      7'b0110000: r = {1'b1, 4'h3};
      7'b0011001: r = {1'b1, 4'h4};
      7'b0010010: r = {1'b1, 4'h5};
      7'b0000010: r = {1'b1, 4'h6};
      7'b1111000: r = {1'b1, 4'h7};
      7'b0000000: r = {1'b1, 4'h8};
      7'b0010000: r = {1'b1, 4'h9};
      7'b0001000: r = {1'b1, 4'hA};
      7'b0000011: r = {1'b1, 4'hB};
      7'b1000110: r = {1'b1, 4'hC};
      7'b0100001: r = {1'b1, 4'hD};
      7'b0000110: r = {1'b1, 4'hE};
      7'b0001110: r = {1'b1, 4'hF};
      default:    r = 5'h00;
    endcase
    return r;
  endfunction

  // Qualification fires on the edge the counter reaches its top, so one dwell acts once.
  always_comb begin
    an_low    = ~held[BUS_W-1:7];
    same      = (sync2 == held);
    qualify   = same && !dwell_done && (stable_cnt == CNT_QUAL);
    one_low   = (an_low != '0) && ((an_low & (an_low - NUM_DIGITS'(1))) == '0);
    capture   = qualify && one_low;
    multi_low = qualify && (an_low != '0) && !one_low;
    dec       = seg_decode(held[6:0]);
    is_blank  = (held[6:0] == SEG_BLANK);
  end

  // Synchronizer, held sample and dwell tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1      <= '1;
      sync2      <= '1;
      held       <= '1;
      stable_cnt <= '0;
      dwell_done <= 1'b0;
    end else begin
      sync1 <= {an_in, seg_in};
      sync2 <= sync1;
      held  <= sync2;
      if (!same) begin
        stable_cnt <= '0;
        dwell_done <= 1'b0;
      end else begin
        if (stable_cnt != CNT_MAX) stable_cnt <= stable_cnt + CNT_W'(1);
        if (qualify) dwell_done <= 1'b1;
      end
    end
  end

  // Per-digit capture and frame assembly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_val   <= '0;
      digit_blank <= '1;
      digit_err   <= '0;
      digit_seen  <= '0;
      frame_valid <= 1'b0;
      frame_count <= '0;
      an_err      <= 1'b0;
    end else begin
      an_err <= multi_low;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (capture && an_low[i]) begin
          digit_val[4*i +: 4] <= dec[4] ? dec[3:0] : 4'h0;
          digit_blank[i]      <= is_blank;
          digit_err[i]        <= !dec[4] && !is_blank;
        end
      end
      if (&digit_seen) begin
        frame_valid <= 1'b1;
        frame_count <= frame_count + FCNT_W'(1);
        digit_seen  <= capture ? an_low : '0;
      end else begin
        frame_valid <= 1'b0;
        if (capture) digit_seen <= digit_seen | an_low;
      end
    end
  end

  // Scan-stall detection; any capture wins over a same-edge timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else if (capture) begin
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else if (idle_cnt == IDLE_MAX) begin
      timeout <= 1'b1;
    end else begin
      idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Bench for sevenseg_scan_decoder: scenario tasks plus a pin-history reference
// model that decides captures from the raw per-edge bus values.
module tb_sevenseg_scan_decoder;

  localparam int unsigned ND = 8;
  localparam int unsigned S  = 4;
  localparam int unsigned T  = 64;
  localparam int unsigned FW = 2;
  localparam logic [6:0] SEG_TBL [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [ND-1:0] an_in = '1;
  logic [6:0]    seg_in = '1;
  logic [4*ND-1:0] digit_val;
  logic [ND-1:0] digit_blank, digit_err, digit_seen;
  logic          frame_valid, an_err, timeout;
  logic [FW-1:0] frame_count;

  int n_checks = 0;
  int n_errors = 0;
  int cyc_bad, obs_fv, obs_anerr;

  // Reference model state
  logic [14:0] hist [$];
  logic [3:0]  m_val [ND];
  logic [ND-1:0] m_blank, m_err, m_seen;
  logic        m_fv, m_anerr, m_to;
  logic [FW-1:0] m_fc;
  int unsigned since_cap;

  sevenseg_scan_decoder #(
    .NUM_DIGITS(ND), .STABLE_CYCLES(S), .TIMEOUT_CYCLES(T), .FCNT_W(FW)
  ) dut (
    .clk(clk), .rst(rst), .an_in(an_in), .seg_in(seg_in),
    .digit_val(digit_val), .digit_blank(digit_blank), .digit_err(digit_err),
    .digit_seen(digit_seen), .frame_valid(frame_valid), .frame_count(frame_count),
    .an_err(an_err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  function automatic logic [4*ND-1:0] m_val_vec();
    logic [4*ND-1:0] v;
    for (int i = 0; i < ND; i++) v[4*i +: 4] = m_val[i];
    return v;
  endfunction

  function automatic logic [ND-1:0] an_for(input int d);
    logic [ND-1:0] a;
    a = '1;
    a[3'(d)] = 1'b0;
    return a;
  endfunction

  task automatic model_reset();
    hist.delete();
    repeat (16) hist.push_front('1);
    for (int i = 0; i < ND; i++) m_val[i] = 4'h0;
    m_blank = '1; m_err = '0; m_seen = '0;
    m_fv = 1'b0; m_anerr = 1'b0; m_to = 1'b0; m_fc = '0;
    since_cap = 0;
  endtask

  // A bus value acts once, STABLE+1 edges after it first appeared, if it lasted exactly S samples so far.
  task automatic model_edge(input logic [14:0] p);
    logic [14:0] x;
    logic [ND-1:0] lows;
    bit run, hit, cap;
    int slot;
    logic [3:0] nib;
    hist.push_front(p);
    if (hist.size() > 16) void'(hist.pop_back());
    m_fv = 1'b0;
    if (m_seen == '1) begin
      m_fv = 1'b1;
      m_fc = m_fc + FW'(1);
      m_seen = '0;
    end
    m_anerr = 1'b0;
    cap = 0;
    x = hist[2];
    run = 1;
    for (int i = 3; i < 2 + S; i++) if (hist[i] != x) run = 0;
    if (hist[2 + S] == x) run = 0;
    if (run) begin
      lows = ~x[14:7];
      if ($countones(lows) == 1) begin
        slot = 0;
        for (int i = 0; i < ND; i++) if (lows[i]) slot = i;
        hit = 0; nib = 4'h0;
        for (int j = 0; j < 16; j++) if (SEG_TBL[j] == x[6:0]) begin hit = 1; nib = 4'(j); end
        m_val[slot]   = hit ? nib : 4'h0;
        m_blank[slot] = (x[6:0] == 7'h7F);
        m_err[slot]   = !hit && (x[6:0] != 7'h7F);
        m_seen[slot]  = 1'b1;
        cap = 1;
      end else if ($countones(lows) > 1) begin
        m_anerr = 1'b1;
      end
    end
    since_cap = cap ? 0 : since_cap + 1;
    m_to = (since_cap >= T);
  endtask

  task automatic step(input logic [ND-1:0] an, input logic [6:0] seg);
    an_in = an;
    seg_in = seg;
    @(posedge clk);
    model_edge({an, seg});
    #1;
    if (digit_val !== m_val_vec() || digit_blank !== m_blank || digit_err !== m_err ||
        digit_seen !== m_seen || frame_valid !== m_fv || frame_count !== m_fc ||
        an_err !== m_anerr || timeout !== m_to) cyc_bad++;
    if (frame_valid === 1'b1) obs_fv++;
    if (an_err === 1'b1) obs_anerr++;
  endtask

  task automatic dwell(input logic [ND-1:0] an, input logic [6:0] seg, input int n);
    repeat (n) step(an, seg);
  endtask

  task automatic scan_all(input logic [4*ND-1:0] vals, input int n);
    for (int d = 0; d < ND; d++) dwell(an_for(d), SEG_TBL[vals[4*d +: 4]], n);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    cyc_bad = 0;
    dwell(an_for(1), SEG_TBL[6], 6);
    dwell(an_for(2), SEG_TBL[6], 3);
    #3 rst = 1'b1;
    #1;
    n_checks++; if (digit_val !== '0) begin n_errors++; $display("FAIL reset_val: got %h expected 0", digit_val); end
    n_checks++; if (digit_blank !== '1) begin n_errors++; $display("FAIL reset_blank: got %h expected ff", digit_blank); end
    n_checks++; if (digit_err !== '0) begin n_errors++; $display("FAIL reset_err: got %h expected 0", digit_err); end
    n_checks++; if (digit_seen !== '0) begin n_errors++; $display("FAIL reset_seen: got %h expected 0", digit_seen); end
    n_checks++; if (frame_valid !== 1'b0) begin n_errors++; $display("FAIL reset_fv: got %b expected 0", frame_valid); end
    n_checks++; if (frame_count !== '0) begin n_errors++; $display("FAIL reset_fc: got %0d expected 0", frame_count); end
    n_checks++; if (an_err !== 1'b0) begin n_errors++; $display("FAIL reset_an_err: got %b expected 0", an_err); end
    n_checks++; if (timeout !== 1'b0) begin n_errors++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    dwell(an_for(2), SEG_TBL[6], 5);
    n_checks++; if (digit_seen !== 8'h00) begin n_errors++; $display("FAIL fresh_dwell_early: seen %h expected 00", digit_seen); end
    step(an_for(2), SEG_TBL[6]);
    n_checks++; if (digit_seen !== 8'h04) begin n_errors++; $display("FAIL fresh_dwell_seen: got %h expected 04", digit_seen); end
    n_checks++; if (digit_val[11:8] !== 4'h6) begin n_errors++; $display("FAIL fresh_dwell_val: got %h expected 6", digit_val[11:8]); end
    n_checks++; if (cyc_bad !== 0) begin n_errors++; $display("FAIL reset_cycles: %0d cycles differ from model, expected 0", cyc_bad); end
  endtask

  task automatic test_single_digit();
    cyc_bad = 0; obs_fv = 0;
    dwell(8'hFE, 7'b0001000, 5);
    n_checks++; if (digit_seen !== 8'h00) begin n_errors++; $display("FAIL single_early: seen %h expected 00", digit_seen); end
    step(8'hFE, 7'b0001000);
    n_checks++; if (digit_val[3:0] !== 4'hA) begin n_errors++; $display("FAIL single_val: got %h expected a", digit_val[3:0]); end
    n_checks++; if (digit_seen !== 8'h01) begin n_errors++; $display("FAIL single_seen: got %h expected 01", digit_seen); end
    n_checks++; if (digit_blank[0] !== 1'b0) begin n_errors++; $display("FAIL single_blank: got %b expected 0", digit_blank[0]); end
    dwell(8'hFE, 7'b0001000, 4);
    n_checks++; if (obs_fv !== 0) begin n_errors++; $display("FAIL single_fv: %0d pulses expected 0", obs_fv); end
    n_checks++; if (cyc_bad !== 0) begin n_errors++; $display("FAIL single_cycles: %0d cycles differ, expected 0", cyc_bad); end
  endtask

  task automatic test_full_frame();
    cyc_bad = 0; obs_fv = 0;
    scan_all(32'h76543210, 6);
    dwell('1, '1, 2);
    n_checks++; if (digit_val !== 32'h76543210) begin n_errors++; $display("FAIL frame_val: got %h expected 76543210", digit_val); end
    n_checks++; if (frame_count !== 2'd1) begin n_errors++; $display("FAIL frame_count1: got %0d expected 1", frame_count); end
    n_checks++; if (digit_seen !== 8'h00) begin n_errors++; $display("FAIL frame_seen: got %h expected 00", digit_seen); end
    n_checks++; if (obs_fv !== 1) begin n_errors++; $display("FAIL frame_pulses1: %0d expected 1", obs_fv); end
    obs_fv = 0;
    scan_all(32'h76543210, 6);
    dwell('1, '1, 2);
    n_checks++; if (frame_count !== 2'd2) begin n_errors++; $display("FAIL frame_count2: got %0d expected 2", frame_count); end
    n_checks++; if (obs_fv !== 1) begin n_errors++; $display("FAIL frame_pulses2: %0d expected 1", obs_fv); end
    n_checks++; if (cyc_bad !== 0) begin n_errors++; $display("FAIL frame_cycles: %0d cycles differ, expected 0", cyc_bad); end
  endtask

  task automatic test_glitch_illegal();
    cyc_bad = 0;
    dwell('1, '1, 2);
    dwell(an_for(3), SEG_TBL[5], 6);
    dwell(an_for(3), SEG_TBL[8], 2);
    dwell(an_for(3), SEG_TBL[5], 3);
    dwell('1, '1, 2);
    n_checks++; if (digit_val[15:12] !== 4'h5) begin n_errors++; $display("FAIL glitch_val: got %h expected 5", digit_val[15:12]); end
    n_checks++; if (digit_seen !== 8'h08) begin n_errors++; $display("FAIL glitch_seen: got %h expected 08", digit_seen); end
    dwell(an_for(2), 7'b1000111, 6);
    n_checks++; if (digit_err[2] !== 1'b1) begin n_errors++; $display("FAIL illegal_err: got %b expected 1", digit_err[2]); end
    n_checks++; if (digit_val[11:8] !== 4'h0) begin n_errors++; $display("FAIL illegal_val: got %h expected 0", digit_val[11:8]); end
    dwell(an_for(2), 7'h7F, 6);
    n_checks++; if (digit_blank[2] !== 1'b1) begin n_errors++; $display("FAIL blank_flag: got %b expected 1", digit_blank[2]); end
    n_checks++; if (digit_err[2] !== 1'b0) begin n_errors++; $display("FAIL blank_err: got %b expected 0", digit_err[2]); end
    n_checks++; if (cyc_bad !== 0) begin n_errors++; $display("FAIL glitch_cycles: %0d cycles differ, expected 0", cyc_bad); end
  endtask

  task automatic test_bus_fault_stall();
    logic [ND-1:0] seen_exp;
    int obs_rise, exp_rise;
    cyc_bad = 0; obs_anerr = 0;
    seen_exp = m_seen;
    dwell(8'hFC, SEG_TBL[1], 8);
    n_checks++; if (obs_anerr !== 1) begin n_errors++; $display("FAIL an_err_pulses: %0d expected 1", obs_anerr); end
    n_checks++; if (digit_seen !== seen_exp) begin n_errors++; $display("FAIL an_err_seen: got %h expected %h", digit_seen, seen_exp); end
    obs_rise = -1; exp_rise = -1;
    for (int i = 0; i < 70; i++) begin
      step('1, '1);
      if (obs_rise < 0 && timeout === 1'b1) obs_rise = i;
      if (exp_rise < 0 && m_to) exp_rise = i;
    end
    n_checks++; if (obs_rise !== exp_rise) begin n_errors++; $display("FAIL timeout_rise: at %0d expected %0d", obs_rise, exp_rise); end
    n_checks++; if (timeout !== 1'b1) begin n_errors++; $display("FAIL timeout_level: got %b expected 1", timeout); end
    dwell(an_for(4), SEG_TBL[4], 5);
    n_checks++; if (timeout !== 1'b1) begin n_errors++; $display("FAIL timeout_hold: got %b expected 1", timeout); end
    step(an_for(4), SEG_TBL[4]);
    n_checks++; if (timeout !== 1'b0) begin n_errors++; $display("FAIL timeout_clear: got %b expected 0", timeout); end
    n_checks++; if (digit_val[19:16] !== 4'h4) begin n_errors++; $display("FAIL timeout_capture: got %h expected 4", digit_val[19:16]); end
    n_checks++; if (cyc_bad !== 0) begin n_errors++; $display("FAIL stall_cycles: %0d cycles differ, expected 0", cyc_bad); end
  endtask

  task automatic test_overwrite_wrap();
    logic [FW-1:0] fc_exp, prev_obs;
    logic [4*ND-1:0] vals;
    bit wrapped;
    cyc_bad = 0;
    dwell(an_for(0), SEG_TBL[3], 6);
    dwell(an_for(0), SEG_TBL[9], 6);
    dwell('1, '1, 1);
    n_checks++; if (digit_val[3:0] !== 4'h9) begin n_errors++; $display("FAIL overwrite_val: got %h expected 9", digit_val[3:0]); end
    n_checks++; if (digit_err[0] !== 1'b0) begin n_errors++; $display("FAIL overwrite_err: got %b expected 0", digit_err[0]); end
    wrapped = 0;
    fc_exp = m_fc;
    prev_obs = frame_count;
    for (int f = 0; f < 4; f++) begin
      vals = $urandom;
      scan_all(vals, 6);
      dwell('1, '1, 2);
      fc_exp = fc_exp + FW'(1);
      n_checks++; if (frame_count !== fc_exp) begin n_errors++; $display("FAIL wrap_count: frame %0d got %0d expected %0d", f, frame_count, fc_exp); end
      n_checks++; if (digit_val !== vals) begin n_errors++; $display("FAIL wrap_val: frame %0d got %h expected %h", f, digit_val, vals); end
      if (prev_obs == 2'd3 && frame_count == 2'd0) wrapped = 1;
      prev_obs = frame_count;
    end
    n_checks++; if (wrapped !== 1'b1) begin n_errors++; $display("FAIL wrap_seen: got %b expected 1", wrapped); end
    n_checks++; if (cyc_bad !== 0) begin n_errors++; $display("FAIL wrap_cycles: %0d cycles differ, expected 0", cyc_bad); end
  endtask

  task automatic test_random();
    int r, len;
    logic [ND-1:0] an;
    logic [6:0] seg;
    cyc_bad = 0;
    for (int k = 0; k < 250; k++) begin
      r   = $urandom_range(0, 99);
      an  = an_for($urandom_range(0, ND - 1));
      seg = SEG_TBL[4'($urandom_range(0, 15))];
      len = $urandom_range(1, 8);
      if (r < 8) seg = 7'h7F;
      else if (r < 16) seg = 7'($urandom);
      else if (r < 22) an = ND'($urandom);
      else if (r < 25) an = '1;
      else if (r >= 97) begin an = '1; len = 70; end
      dwell(an, seg, len);
    end
    dwell('1, '1, 2);
    n_checks++; if (digit_val !== m_val_vec()) begin n_errors++; $display("FAIL rand_val: got %h expected %h", digit_val, m_val_vec()); end
    n_checks++; if (digit_blank !== m_blank) begin n_errors++; $display("FAIL rand_blank: got %h expected %h", digit_blank, m_blank); end
    n_checks++; if (digit_err !== m_err) begin n_errors++; $display("FAIL rand_err: got %h expected %h", digit_err, m_err); end
    n_checks++; if (digit_seen !== m_seen) begin n_errors++; $display("FAIL rand_seen: got %h expected %h", digit_seen, m_seen); end
    n_checks++; if (frame_count !== m_fc) begin n_errors++; $display("FAIL rand_fc: got %0d expected %0d", frame_count, m_fc); end
    n_checks++; if (timeout !== m_to) begin n_errors++; $display("FAIL rand_timeout: got %b expected %b", timeout, m_to); end
    n_checks++; if (cyc_bad !== 0) begin n_errors++; $display("FAIL rand_cycles: %0d cycles differ, expected 0", cyc_bad); end
  endtask

  initial begin
    model_reset();
    apply_reset();
    test_reset();
    apply_reset();
    test_single_digit();
    test_full_frame();
    test_glitch_illegal();
    test_bus_fault_stall();
    test_overwrite_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_decoder.md
Name: sevenseg_scan_decoder

Overview:
Receive-side counterpart of our board display drivers. It samples the multiplexed active-low anode/segment bus and captures each digit's pattern once the bus is stable. It decodes each pattern back to a hex nibble and rebuilds the full N-digit display value, flagging frames, illegal patterns, bus faults and scan stalls. Used for display self-check and loopback, and for feeding the displayed value back to the FSM or a UART logger.

Parameters:
NUM_DIGITS, 8, number of anodes scanned
STABLE_CYCLES, 4, consecutive identical synchronized samples required before a capture (>=2)
TIMEOUT_CYCLES, 1000000, capture-free cycles before timeout asserts
FCNT_W, 16, frame counter width

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
an_in  in  NUM_DIGITS  anode enables, active-low, bit i = digit i
seg_in  in  7  segments, active-low, order {g,f,e,d,c,b,a} (seg_in[0]=a)
digit_val  out  4*NUM_DIGITS  decoded nibbles, digit i at [4i+3:4i]
digit_blank  out  NUM_DIGITS  1 = last capture for digit was blank (7'b1111111)
digit_err  out  NUM_DIGITS  1 = last capture for digit was an unknown pattern
digit_seen  out  NUM_DIGITS  digits captured in current frame
frame_valid  out  1  one-cycle pulse: every digit captured since last frame
frame_count  out  FCNT_W  completed frames, wraps
an_err  out  1  one-cycle pulse: stable dwell with >1 anode low
timeout  out  1  level: no capture for TIMEOUT_CYCLES

Behaviour:
- Reset (async) clears the following:
  - digit_val=0, digit_blank=all 1, digit_err=0, digit_seen=0
  - frame_valid=0, an_err=0, frame_count=0, timeout=0
  - sync/held registers=all 1 (dark bus), stable counter=0, idle counter=0
- Input path: 2-flop synchronizer on {an_in,seg_in}, then one held-sample register.
- Dwell tracking:
  - When the synchronized sample differs from the held sample: stable counter=0 and dwell_done cleared.
  - Otherwise the counter increments, saturating at STABLE_CYCLES-1.
- Dwell qualification: the counter at STABLE_CYCLES-1 with dwell_done=0 qualifies the dwell and sets dwell_done. Exactly one action per dwell:
  - exactly one anode low (index i): capture into slot i;
  - no anode low: no action;
  - more than one anode low: pulse an_err, no capture.
- Latency: a pin value first clocked at edge E updates the outputs at edge E+STABLE_CYCLES+1. Changes shorter than STABLE_CYCLES samples are never captured.
- Decode table (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Capture results for slot i:
  - table hit: val=nibble, blank=0, err=0;
  - 1111111: val=0, blank=1, err=0;
  - any other pattern: val=0, blank=0, err=1.
- Frame:
  - Each capture sets digit_seen[i]. A re-capture of an already-seen digit is legal: it overwrites the value, no error.
  - On the edge after the capture that makes digit_seen all ones: frame_valid=1 for one cycle, frame_count+1 (wraps to 0 at max), digit_seen cleared.
  - digit_val/blank/err persist across frames.
- Timeout:
  - The idle counter increments each cycle and clears on any capture.
  - At TIMEOUT_CYCLES-1, timeout=1 and the counter saturates.
  - timeout drops on the edge of the next capture. an_err dwells do not clear it.
- Simultaneous events: a capture and a timeout clear on the same edge resolve as capture applied and timeout=0.
- Reset mid-dwell or mid-frame discards all partial state immediately. The first capture after reset requires a full fresh dwell.

Test Plan:
1. Reset: assert rst mid-operation -> all outputs at reset values within the same cycle, with no clock needed.
2. Single digit (STABLE_CYCLES=4): an=11111110, seg=0001000 for 10 cycles -> digit_val[3:0]=4'hA, digit_seen=8'h01, exactly one capture, outputs update at E+5, frame_valid stays 0.
3. Full frame: scan digits 0..7 showing 0,1,...,7, 6 cycles each -> one frame_valid pulse after the digit 7 capture, digit_val=32'h76543210, frame_count=1, digit_seen=0. Repeat the scan -> frame_count=2.
4. Glitch and illegal pattern:
   - 2-cycle seg change inside a digit-3 dwell -> digit 3 keeps its value, no extra capture.
   - seg=1000111 on digit 2 -> digit_err[2]=1, digit_val nibble 2=0.
   - seg=1111111 on digit 2 -> digit_blank[2]=1.
5. Bus fault and stall (TIMEOUT_CYCLES=64):
   - an=11111100 stable -> one an_err pulse, no capture, digit_seen unchanged.
   - Then all anodes high for 70 cycles -> timeout=1 from cycle 64.
   - Then a valid digit dwell -> timeout=0 on the capture edge.
6. Overwrite and wrap (FCNT_W=2): digit 0 captured twice with 3 then 9 within one frame -> nibble 0=9, no error. Run 4 frames -> frame_count wraps 3->0.
